// File: rtl/multicycle_adder_flags.sv
// multicycle_adder_flags: sliced ripple adder/subtractor with flags and valid/ready handshakes
module multicycle_adder_flags #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             parity,
    output logic             overflow,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d, z_new;
    logic             cin_q, cin_d, cry_q, cry_d, last;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       flg_q, flg_d;
    logic [SLICE:0]   sum;
    int               idx;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        cin_d   = cin_q;
        cry_d   = cry_q;
        cnt_d   = cnt_q;
        flg_d   = flg_q;
        idx     = int'(cnt_q) * SLICE;
        sum     = {1'b0, a_q[idx +: SLICE]} + {1'b0, b_q[idx +: SLICE]} + {{SLICE{1'b0}}, cin_q};
        z_new   = z_q;
        z_new[idx +: SLICE] = sum[SLICE-1:0];
        last    = cnt_q == CW'(NSLICE - 1);
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = op[0] ? ~b : b;
            cin_d   = op[1] ? cry_q : op[0];
            cnt_d   = '0;
            state_d = BUSY;
        end else if (state_q == BUSY) begin
            // cin_q doubles as the inter-slice running carry
            z_d   = z_new;
            cin_d = sum[SLICE];
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (last) begin
                state_d = DONE;
                cry_d   = sum[SLICE];
                flg_d   = {sum[SLICE], ~|z_new, z_new[WIDTH-1], ~^z_new,
                           (a_q[WIDTH-1] == b_q[WIDTH-1]) && (z_new[WIDTH-1] != a_q[WIDTH-1])};
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            cin_q   <= 1'b0;
            cry_q   <= 1'b0;
            cnt_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cin_q   <= cin_d;
            cry_q   <= cry_d;
            cnt_q   <= cnt_d;
            flg_q   <= flg_d;
        end
    end
    assign in_ready  = state_q == IDLE && !rst;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign z         = z_q;
    assign {carry, zero, sign, parity, overflow} = flg_q;
endmodule
